// File: rtl/param_rf_if.sv
// Write / read / clear bundle for the param_rf register file.
// The master side drives requests; the slave side is the register file itself.
interface param_rf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_ready;
  logic [NRD*ADDR_W-1:0]  rd_addr;
  logic [NRD*DATA_W-1:0]  rd_data;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  wr_ready, rd_data, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output wr_ready, rd_data, clr_busy, clr_done
  );
endinterface

// File: rtl/param_rf.sv
// Parameterised register file: NRD combinational read ports, one write port, sequential flash-clear.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module param_rf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  param_rf_if.slave   rf
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_wr_ready;
  logic               w_clr_busy;
  logic               w_clr_done;
  logic               w_ptr_last;
  logic               w_wr_zero;
  logic               w_wr_commit;
  logic [ADDR_W-1:0]  w_ra;
  logic [NRD*DATA_W-1:0] w_rd_data;

  assign w_ptr_last  = (r_ptr == {ADDR_W{1'b1}});
  // Writes to a hardwired-zero entry are acknowledged but dropped.
  assign w_wr_zero   = (ZERO_REG != 0) && (rf.wr_addr == {ADDR_W{1'b0}});
  assign w_wr_commit = rf.wr_en && w_wr_ready && !w_wr_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b1;
    w_clr_busy  = 1'b0;
    w_clr_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rf.clr_req) w_state_nxt = ST_CLEAR;
        else            w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        w_wr_ready = 1'b0;
        w_clr_busy = 1'b1;
        if (w_ptr_last) w_state_nxt = ST_DONE;
        else            w_state_nxt = ST_CLEAR;
      end
      ST_DONE: begin
        w_clr_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_ptr <= r_ptr + ADDR_W'(1);
      else                     r_ptr <= {ADDR_W{1'b0}};
    end
  end

  // Clear sweep has priority over the write port; the write port is stalled meanwhile.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_commit) begin
      r_mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      w_ra = rf.rd_addr[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (w_ra == {ADDR_W{1'b0}})) begin
        w_rd_data[k*DATA_W +: DATA_W] = '0;
      end
`ifdef RF_BYPASS_EN
      else if (rf.wr_en && w_wr_ready && (w_ra == rf.wr_addr)) begin
        w_rd_data[k*DATA_W +: DATA_W] = rf.wr_data;
      end
`endif
      else begin
        w_rd_data[k*DATA_W +: DATA_W] = r_mem[w_ra];
      end
    end
  end

  assign rf.wr_ready = w_wr_ready;
  assign rf.clr_busy = w_clr_busy;
  assign rf.clr_done = w_clr_done;
  assign rf.rd_data  = w_rd_data;
endmodule

// File: tb/tb_param_rf.sv
// Directed, table-driven bench for param_rf (DATA_W=32, ADDR_W=5, NRD=2, ZERO_REG=1).
// Expected values follow RF_BYPASS_EN when the bench is built with it.
module tb_param_rf;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  param_rf_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

  param_rf #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rf    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic cr);
    bus.wr_en        = we;
    bus.wr_addr      = wa;
    bus.wr_data      = wd;
    bus.rd_addr[4:0] = ra0;
    bus.rd_addr[9:5] = ra1;
    bus.clr_req      = cr;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd_data[63:32];
  endfunction

  int busy_cnt;
  logic [31:0] exp1;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd5,  BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h1234_5678 : 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'h1234_5678};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
    vecs[4] = '{1'b1, 5'd3,  32'h0000_BEEF, 5'd3,  5'd3,  BYP ? 32'hBEEF : 32'h0, BYP ? 32'hBEEF : 32'h0};
    vecs[5] = '{1'b1, 5'd3,  32'h0000_1234, 5'd3,  5'd5,  BYP ? 32'h1234 : 32'hBEEF, 32'h1234_5678};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd1,  32'h1234,      32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd30, BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd30, 5'd31, 32'h0,         32'hDEAD_BEEF};

    // Reset with write and clear requests pending; both must be ignored.
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h55, 5'd5, 5'd5, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
    #2;
    chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("reset_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("reset_clr_done", 32'(bus.clr_done), 32'd0);
    chk("reset_rd0", rd0(), 32'h0);
    chk("reset_rd1", rd1(), 32'h0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1, 1'b0);
      #2;
      chk($sformatf("vec%0d_rd0", i), rd0(), vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd1(), vecs[i].e1);
      chk($sformatf("vec%0d_ready", i), 32'(bus.wr_ready), 32'd1);
    end

    // Fill 1..31 with their index, then clear with a simultaneous write to 9.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b1, 5'(a), 32'(a), 5'd0, 5'd0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b1);

    // Hold a write to 7 through the sweep; re-request clear mid-sweep and in DONE.
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd7, 32'hA5, 5'(c - 1), 5'(c), (c == 5) || (c == 32));
      #2;
      if (!bus.clr_busy) break;
      busy_cnt++;
      chk($sformatf("clr%0d_ready", c), 32'(bus.wr_ready), 32'd0);
      chk($sformatf("clr%0d_done", c), 32'(bus.clr_done), 32'd0);
      chk($sformatf("clr%0d_below_ptr", c), rd0(), (c == 0) ? 32'd31 : 32'd0);
      exp1 = (c == 0) ? 32'd0 : ((c == 9) ? 32'h99 : 32'(c));
      chk($sformatf("clr%0d_at_ptr", c), rd1(), exp1);
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("done_pulse", 32'(bus.clr_done), 32'd1);
    chk("done_ready", 32'(bus.wr_ready), 32'd1);
    chk("done_busy", 32'(bus.clr_busy), 32'd0);

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b0);
    #2;
    chk("post_done_pulse", 32'(bus.clr_done), 32'd0);
    chk("post_done_no_restart", 32'(bus.clr_busy), 32'd0);
    chk("post_done_rd7", rd0(), 32'hA5);
    chk("post_done_rd9", rd1(), 32'h0);
    for (int a = 1; a < 32; a++) begin
      if (a == 7) continue;
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'd0, 1'b0);
      #2;
      chk($sformatf("cleared_rd%0d", a), rd0(), 32'h0);
    end

    // Reset in the middle of a clear sweep.
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h20, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd25, 32'h25, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd25, 1'b1);
    #2;
    chk("pre_abort_rd20", rd0(), 32'h20);
    chk("pre_abort_rd25", rd1(), 32'h25);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd25, 1'b0);
    end
    #2;
    chk("abort_busy_before", 32'(bus.clr_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd20, 32'h77, 5'd20, 5'd25, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd25, 1'b0);
    #2;
    chk("abort_busy", 32'(bus.clr_busy), 32'd0);
    chk("abort_ready", 32'(bus.wr_ready), 32'd1);
    chk("abort_rd20", rd0(), 32'h0);
    chk("abort_rd25", rd1(), 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort_no_done%0d", c), 32'(bus.clr_done), 32'd0);
      @(negedge clk);
      #2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
